// File: rtl/ramb_tdp_param.sv
// Parametrised single-clock true dual-port RAM with per-lane parity and write enables,
// per-port write modes, optional output register, collision flag and post-reset clear.
module ramb_tdp_param #(
    parameter int                NB             = 1,
    parameter int                ADDR_W         = 11,
    parameter string             WRITE_MODE_A   = "WRITE_FIRST",
    parameter string             WRITE_MODE_B   = "WRITE_FIRST",
    parameter int                DO_REG         = 0,
    parameter logic [9*NB-1:0]   INIT_A         = '0,
    parameter logic [9*NB-1:0]   INIT_B         = '0,
    parameter logic [9*NB-1:0]   SRVAL_A        = '0,
    parameter logic [9*NB-1:0]   SRVAL_B        = '0,
    parameter int                CLEAR_ON_RESET = 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [ADDR_W-1:0]   i_addra,
    input  logic [8*NB-1:0]     i_dia,
    input  logic [NB-1:0]       i_dipa,
    input  logic [NB-1:0]       i_wea,
    input  logic                i_ena,
    input  logic                i_ssra,
    input  logic [ADDR_W-1:0]   i_addrb,
    input  logic [8*NB-1:0]     i_dib,
    input  logic [NB-1:0]       i_dipb,
    input  logic [NB-1:0]       i_web,
    input  logic                i_enb,
    input  logic                i_ssrb,
    output logic [8*NB-1:0]     o_doa,
    output logic [NB-1:0]       o_dopa,
    output logic [8*NB-1:0]     o_dob,
    output logic [NB-1:0]       o_dopb,
    output logic                o_busy,
    output logic                o_coll
);

    localparam int DW    = 9 * NB;
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] MODE_WF = 2'd0;
    localparam logic [1:0] MODE_RF = 2'd1;
    localparam logic [1:0] MODE_NC = 2'd2;

    localparam logic [1:0] MODE_A = (WRITE_MODE_A == "READ_FIRST") ? MODE_RF :
                                    (WRITE_MODE_A == "NO_CHANGE")  ? MODE_NC : MODE_WF;
    localparam logic [1:0] MODE_B = (WRITE_MODE_B == "READ_FIRST") ? MODE_RF :
                                    (WRITE_MODE_B == "NO_CHANGE")  ? MODE_NC : MODE_WF;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    localparam state_t S_RST = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_clr_addr;
    logic                r_busy;
    logic                r_coll;
    logic [DW-1:0]       r_mem [DEPTH];
    logic [DW-1:0]       r_s1a;
    logic [DW-1:0]       r_s1b;
    logic [DW-1:0]       r_s2a;
    logic [DW-1:0]       r_s2b;

    logic                w_ready;
    logic                w_ena;
    logic                w_enb;
    logic                w_coll;
    logic [DW-1:0]       w_olda;
    logic [DW-1:0]       w_oldb;

    // Word layout is {parity[NB-1:0], data[8*NB-1:0]}; lane i owns data byte i and parity bit i.
    function automatic logic [DW-1:0] f_merge(input logic [DW-1:0]   old,
                                              input logic [8*NB-1:0] di,
                                              input logic [NB-1:0]   dip,
                                              input logic [NB-1:0]   we);
        logic [DW-1:0] v;
        v = old;
        for (int i = 0; i < NB; i++) begin
            if (we[i]) begin
                v[8*i +: 8]  = di[8*i +: 8];
                v[8*NB + i]  = dip[i];
            end
        end
        return v;
    endfunction

    function automatic logic [DW-1:0] f_stage1(input logic [1:0]    mode,
                                               input logic          ssr,
                                               input logic [NB-1:0] we,
                                               input logic [DW-1:0] old,
                                               input logic [DW-1:0] merged,
                                               input logic [DW-1:0] hold,
                                               input logic [DW-1:0] srval);
        logic [DW-1:0] v;
        if (ssr) begin
            v = srval;
        end else if (we == {NB{1'b0}}) begin
            v = old;
        end else begin
            case (mode)
                MODE_WF: v = merged;
                MODE_RF: v = old;
                default: v = hold;
            endcase
        end
        return v;
    endfunction

    assign w_ready = (r_state == S_READY);
    assign w_ena   = i_ena & w_ready;
    assign w_enb   = i_enb & w_ready;
    assign w_coll  = w_ena & w_enb & (i_addra == i_addrb) & ((|i_wea) | (|i_web));
    assign w_olda  = r_mem[i_addra];
    assign w_oldb  = r_mem[i_addrb];

    // Clear FSM next state: walk every address once, then stay ready.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CLEAR: begin
                if (r_clr_addr == {ADDR_W{1'b1}}) begin
                    w_state_nxt = S_READY;
                end else begin
                    w_state_nxt = S_CLEAR;
                end
            end
            S_READY: w_state_nxt = S_READY;
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    // Clear FSM state, address counter and busy flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_RST;
            r_clr_addr <= {ADDR_W{1'b0}};
            r_busy     <= (CLEAR_ON_RESET != 0);
        end else begin
            r_state    <= w_state_nxt;
            r_busy     <= (w_state_nxt == S_CLEAR);
            if (r_state == S_CLEAR) begin
                r_clr_addr <= r_clr_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
            end else begin
                r_clr_addr <= r_clr_addr;
            end
        end
    end

    // Array writes; port A lanes are applied last so they win a same-address write.
    always_ff @(posedge i_clk) begin
        if (r_state == S_CLEAR) begin
            r_mem[r_clr_addr] <= {DW{1'b0}};
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (w_enb && i_web[i]) begin
                    r_mem[i_addrb][8*i +: 8] <= i_dib[8*i +: 8];
                    r_mem[i_addrb][8*NB + i] <= i_dipb[i];
                end
            end
            for (int i = 0; i < NB; i++) begin
                if (w_ena && i_wea[i]) begin
                    r_mem[i_addra][8*i +: 8] <= i_dia[8*i +: 8];
                    r_mem[i_addra][8*NB + i] <= i_dipa[i];
                end
            end
        end
    end

    // Output latches (stage 1), optional pipeline (stage 2) and collision pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1a  <= INIT_A;
            r_s2a  <= INIT_A;
            r_s1b  <= INIT_B;
            r_s2b  <= INIT_B;
            r_coll <= 1'b0;
        end else begin
            if (w_ena) begin
                r_s1a <= f_stage1(MODE_A, i_ssra, i_wea, w_olda,
                                  f_merge(w_olda, i_dia, i_dipa, i_wea), r_s1a, SRVAL_A);
            end else begin
                r_s1a <= r_s1a;
            end
            if (w_enb) begin
                r_s1b <= f_stage1(MODE_B, i_ssrb, i_web, w_oldb,
                                  f_merge(w_oldb, i_dib, i_dipb, i_web), r_s1b, SRVAL_B);
            end else begin
                r_s1b <= r_s1b;
            end
            r_s2a  <= r_s1a;
            r_s2b  <= r_s1b;
            r_coll <= w_coll;
        end
    end

    assign o_doa  = (DO_REG != 0) ? r_s2a[8*NB-1:0]  : r_s1a[8*NB-1:0];
    assign o_dopa = (DO_REG != 0) ? r_s2a[DW-1:8*NB] : r_s1a[DW-1:8*NB];
    assign o_dob  = (DO_REG != 0) ? r_s2b[8*NB-1:0]  : r_s1b[8*NB-1:0];
    assign o_dopb = (DO_REG != 0) ? r_s2b[DW-1:8*NB] : r_s1b[DW-1:8*NB];
    assign o_busy = r_busy;
    assign o_coll = r_coll;

endmodule

// File: tb/tb_ramb_tdp_param.sv
// Bench for ramb_tdp_param: two configurations (NB=2 WF/RF no output reg, NB=1 WF/NC with
// output reg) driven together and compared against a behavioural word-array model.
module tb_ramb_tdp_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        en  [2][2];
    logic        ssr [2][2];
    logic [1:0]  we  [2][2];
    logic [3:0]  addr[2][2];
    logic [15:0] di  [2][2];
    logic [1:0]  dip [2][2];

    logic [15:0] doa0, dob0;
    logic [1:0]  dopa0, dopb0;
    logic [7:0]  doa1, dob1;
    logic        dopa1, dopb1;
    logic        busy0, busy1, coll0, coll1;

    int checks = 0;
    int errors = 0;

    ramb_tdp_param #(
        .NB(2), .ADDR_W(4), .WRITE_MODE_A("WRITE_FIRST"), .WRITE_MODE_B("READ_FIRST"),
        .DO_REG(0), .INIT_A(18'h2BEEF), .INIT_B(18'h1CAFE),
        .SRVAL_A(18'h30F0F), .SRVAL_B(18'h0F00D), .CLEAR_ON_RESET(1)
    ) dut0 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_addra(addr[0][0]), .i_dia(di[0][0]), .i_dipa(dip[0][0]), .i_wea(we[0][0]),
        .i_ena(en[0][0]), .i_ssra(ssr[0][0]),
        .i_addrb(addr[0][1]), .i_dib(di[0][1]), .i_dipb(dip[0][1]), .i_web(we[0][1]),
        .i_enb(en[0][1]), .i_ssrb(ssr[0][1]),
        .o_doa(doa0), .o_dopa(dopa0), .o_dob(dob0), .o_dopb(dopb0),
        .o_busy(busy0), .o_coll(coll0)
    );

    ramb_tdp_param #(
        .NB(1), .ADDR_W(4), .WRITE_MODE_A("WRITE_FIRST"), .WRITE_MODE_B("NO_CHANGE"),
        .DO_REG(1), .INIT_A(9'h1C3), .INIT_B(9'h03C),
        .SRVAL_A(9'h1FF), .SRVAL_B(9'h0A5), .CLEAR_ON_RESET(1)
    ) dut1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_addra(addr[1][0]), .i_dia(di[1][0][7:0]), .i_dipa(dip[1][0][0:0]), .i_wea(we[1][0][0:0]),
        .i_ena(en[1][0]), .i_ssra(ssr[1][0]),
        .i_addrb(addr[1][1]), .i_dib(di[1][1][7:0]), .i_dipb(dip[1][1][0:0]), .i_web(we[1][1][0:0]),
        .i_enb(en[1][1]), .i_ssrb(ssr[1][1]),
        .o_doa(doa1), .o_dopa(dopa1), .o_dob(dob1), .o_dopb(dopb1),
        .o_busy(busy1), .o_coll(coll1)
    );

    // Model words are {parity[1:0], data[15:0]}; the NB=1 instance uses lane 0 only.
    logic [15:0] m_d [2][16];
    logic [1:0]  m_p [2][16];
    logic [17:0] m_s1[2][2];
    logic [17:0] m_s2[2][2];
    logic        m_coll[2];
    logic        m_busy;
    int          m_clr;

    function automatic logic [17:0] f_init(input int d, input int p);
        case ({d[0], p[0]})
            2'b00:   return 18'h2BEEF;
            2'b01:   return 18'h1CAFE;
            2'b10:   return 18'h100C3;
            default: return 18'h0003C;
        endcase
    endfunction

    function automatic logic [17:0] f_srval(input int d, input int p);
        case ({d[0], p[0]})
            2'b00:   return 18'h30F0F;
            2'b01:   return 18'h0F00D;
            2'b10:   return 18'h100FF;
            default: return 18'h000A5;
        endcase
    endfunction

    // 0 = write-first, 1 = read-first, 2 = no-change
    function automatic int f_mode(input int d, input int p);
        if (p == 0) return 0;
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic int f_nb(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic logic [17:0] obs(input int d, input int p);
        case ({d[0], p[0]})
            2'b00:   return {dopa0, doa0};
            2'b01:   return {dopb0, dob0};
            2'b10:   return {1'b0, dopa1, 8'h00, doa1};
            default: return {1'b0, dopb1, 8'h00, dob1};
        endcase
    endfunction

    function automatic logic [17:0] exp_out(input int d, input int p);
        return (d == 1) ? m_s2[d][p] : m_s1[d][p];
    endfunction

    function automatic logic [1:0] obs_bc(input int d);
        return (d == 0) ? {busy0, coll0} : {busy1, coll1};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                m_s1[d][p] = f_init(d, p);
                m_s2[d][p] = f_init(d, p);
            end
            m_coll[d] = 1'b0;
        end
        m_busy = 1'b1;
        m_clr  = 0;
    endtask

    task automatic model_edge();
        logic [17:0] old;
        logic [17:0] nw;
        logic [1:0]  wm [2];
        int          a;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                m_s2[d][p] = m_s1[d][p];
                wm[p] = we[d][p] & ((d == 0) ? 2'b11 : 2'b01);
            end
            m_coll[d] = 1'b0;
            if (!m_busy) begin
                for (int p = 0; p < 2; p++) begin
                    a   = int'(addr[d][p]);
                    old = {m_p[d][a], m_d[d][a]};
                    nw  = old;
                    for (int l = 0; l < f_nb(d); l++) begin
                        if (wm[p][l]) begin
                            nw[8*l +: 8] = di[d][p][8*l +: 8];
                            nw[16 + l]   = dip[d][p][l];
                        end
                    end
                    if (en[d][p]) begin
                        if (ssr[d][p])              m_s1[d][p] = f_srval(d, p);
                        else if (wm[p] == 2'b00)    m_s1[d][p] = old;
                        else if (f_mode(d, p) == 0) m_s1[d][p] = nw;
                        else if (f_mode(d, p) == 1) m_s1[d][p] = old;
                    end
                end
                m_coll[d] = en[d][0] && en[d][1] && (addr[d][0] == addr[d][1]) &&
                            ((wm[0] | wm[1]) != 2'b00);
                for (int p = 1; p >= 0; p--) begin
                    a = int'(addr[d][p]);
                    if (en[d][p]) begin
                        for (int l = 0; l < f_nb(d); l++) begin
                            if (wm[p][l]) begin
                                m_d[d][a][8*l +: 8] = di[d][p][8*l +: 8];
                                m_p[d][a][l]        = dip[d][p][l];
                            end
                        end
                    end
                end
            end
        end
        if (m_busy) begin
            for (int d = 0; d < 2; d++) begin
                m_d[d][m_clr] = 16'h0000;
                m_p[d][m_clr] = 2'b00;
            end
            m_clr++;
            if (m_clr == 16) m_busy = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic idle();
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                en[d][p] = 1'b0; ssr[d][p] = 1'b0; we[d][p] = 2'b00;
                addr[d][p] = 4'h0; di[d][p] = 16'h0000; dip[d][p] = 2'b00;
            end
        end
    endtask

    task automatic rand_inputs();
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                en[d][p]   = ($urandom_range(0, 3) != 0);
                ssr[d][p]  = ($urandom_range(0, 7) == 0);
                we[d][p]   = $urandom_range(0, 1) ? 2'($urandom_range(1, 3)) : 2'b00;
                addr[d][p] = 4'($urandom_range(0, 3));
                di[d][p]   = 16'($urandom);
                dip[d][p]  = 2'($urandom);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < 2; p++) begin
                    checks++;
                    if (obs(d, p) !== f_init(d, p)) begin
                        errors++;
                        $display("FAIL reset_out d%0d p%0d: got %h expected %h", d, p, obs(d, p), f_init(d, p));
                    end
                end
                checks++;
                if (obs_bc(d) !== 2'b10) begin
                    errors++;
                    $display("FAIL reset_busy_coll d%0d: got %b expected 10", d, obs_bc(d));
                end
            end
            rand_inputs();
            step();
        end
    endtask

    task automatic test_clear();
        int n;
        rst_n = 1'b1;
        n = 0;
        while (busy0 && n < 40) begin
            rand_inputs();
            step();
            n++;
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < 2; p++) begin
                    checks++;
                    if (obs(d, p) !== exp_out(d, p)) begin
                        errors++;
                        $display("FAIL clear_out d%0d p%0d: got %h expected %h", d, p, obs(d, p), exp_out(d, p));
                    end
                end
                checks++;
                if (obs_bc(d) !== {m_busy, m_coll[d]}) begin
                    errors++;
                    $display("FAIL clear_busy_coll d%0d: got %b expected %b", d, obs_bc(d), {m_busy, m_coll[d]});
                end
            end
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL clear_len: got %0d cycles expected 16", n);
        end
        idle();
        for (int a = 0; a <= 16; a++) begin
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < 2; p++) begin
                    en[d][p] = (a < 16); addr[d][p] = 4'(a);
                end
            end
            step();
            if (a < 16) begin
                for (int p = 0; p < 2; p++) begin
                    checks++;
                    if (obs(0, p) !== 18'h00000) begin
                        errors++;
                        $display("FAIL clear_zero a%0d p%0d: got %h expected 00000", a, p, obs(0, p));
                    end
                end
            end
            if (a > 0) begin
                for (int p = 0; p < 2; p++) begin
                    checks++;
                    if (obs(1, p) !== exp_out(1, p)) begin
                        errors++;
                        $display("FAIL clear_zero1 a%0d p%0d: got %h expected %h", a, p, obs(1, p), exp_out(1, p));
                    end
                end
            end
        end
    endtask

    task automatic test_write_first_merge();
        idle();
        en[0][0] = 1'b1; we[0][0] = 2'b11; addr[0][0] = 4'd5; di[0][0] = 16'h1234;
        step();
        we[0][0] = 2'b10; di[0][0] = 16'hAB00; dip[0][0] = 2'b10;
        step();
        checks++;
        if (obs(0, 0) !== 18'h2AB34) begin
            errors++;
            $display("FAIL wf_merge: got %h expected 2ab34", obs(0, 0));
        end
        we[0][0] = 2'b00; di[0][0] = 16'h0000;
        step();
        checks++;
        if (obs(0, 0) !== 18'h2AB34 || exp_out(0, 0) !== 18'h2AB34) begin
            errors++;
            $display("FAIL wf_reread: got %h expected 2ab34 (model %h)", obs(0, 0), exp_out(0, 0));
        end
    endtask

    task automatic test_read_first_no_change();
        idle();
        en[0][1] = 1'b1; we[0][1] = 2'b11; addr[0][1] = 4'd7; di[0][1] = 16'h0055;
        en[1][1] = 1'b1; addr[1][1] = 4'd7;
        step();
        di[0][1] = 16'h00AA;
        we[1][1] = 2'b01; di[1][1] = 16'h0077;
        step();
        checks++;
        if (obs(0, 1) !== 18'h00055) begin
            errors++;
            $display("FAIL rf_old: got %h expected 00055", obs(0, 1));
        end
        we[0][1] = 2'b00;
        en[1][1] = 1'b0; we[1][1] = 2'b00;
        step();
        checks++;
        if (obs(0, 1) !== 18'h000AA) begin
            errors++;
            $display("FAIL rf_reread: got %h expected 000aa", obs(0, 1));
        end
        checks++;
        if (obs(1, 1) !== 18'h00000) begin
            errors++;
            $display("FAIL nc_hold: got %h expected 00000", obs(1, 1));
        end
        en[1][1] = 1'b1;
        step();
        en[1][1] = 1'b0;
        step();
        checks++;
        if (obs(1, 1) !== 18'h00077) begin
            errors++;
            $display("FAIL nc_reread: got %h expected 00077", obs(1, 1));
        end
    endtask

    task automatic test_collision();
        idle();
        en[0][0] = 1'b1; we[0][0] = 2'b11; addr[0][0] = 4'd3; di[0][0] = 16'h0011; dip[0][0] = 2'b01;
        en[0][1] = 1'b1; we[0][1] = 2'b11; addr[0][1] = 4'd3; di[0][1] = 16'h0022; dip[0][1] = 2'b10;
        step();
        checks++;
        if (coll0 !== 1'b1) begin
            errors++;
            $display("FAIL coll_pulse: got %b expected 1", coll0);
        end
        idle();
        step();
        checks++;
        if (coll0 !== 1'b0) begin
            errors++;
            $display("FAIL coll_end: got %b expected 0", coll0);
        end
        en[0][0] = 1'b1; addr[0][0] = 4'd3;
        step();
        checks++;
        if (obs(0, 0) !== 18'h10011) begin
            errors++;
            $display("FAIL coll_ww_winner: got %h expected 10011", obs(0, 0));
        end
        we[0][0] = 2'b11; di[0][0] = 16'h0033;
        en[0][1] = 1'b1; addr[0][1] = 4'd3;
        step();
        checks++;
        if (obs(0, 1) !== 18'h10011 || coll0 !== 1'b1) begin
            errors++;
            $display("FAIL coll_rw_old: got %h coll %b expected 10011 coll 1", obs(0, 1), coll0);
        end
    endtask

    task automatic test_do_reg();
        idle();
        en[1][1] = 1'b1; we[1][1] = 2'b01; addr[1][1] = 4'd2; di[1][1] = 16'h005A;
        step();
        idle();
        en[1][0] = 1'b1; addr[1][0] = 4'd2;
        step();
        checks++;
        if (obs(1, 0) !== exp_out(1, 0) || obs(1, 0) === 18'h0005A) begin
            errors++;
            $display("FAIL doreg_edge1: got %h expected %h", obs(1, 0), exp_out(1, 0));
        end
        en[1][0] = 1'b0;
        step();
        checks++;
        if (obs(1, 0) !== 18'h0005A) begin
            errors++;
            $display("FAIL doreg_edge2: got %h expected 0005a", obs(1, 0));
        end
        en[1][0] = 1'b1; ssr[1][0] = 1'b1;
        step();
        idle();
        step();
        checks++;
        if (obs(1, 0) !== 18'h100FF) begin
            errors++;
            $display("FAIL doreg_ssr: got %h expected 100ff", obs(1, 0));
        end
    endtask

    task automatic test_random(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            rand_inputs();
            step();
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < 2; p++) begin
                    checks++;
                    if (obs(d, p) !== exp_out(d, p)) begin
                        errors++;
                        $display("FAIL rand_out c%0d d%0d p%0d: got %h expected %h", c, d, p, obs(d, p), exp_out(d, p));
                    end
                end
                checks++;
                if (obs_bc(d) !== {m_busy, m_coll[d]}) begin
                    errors++;
                    $display("FAIL rand_busy_coll c%0d d%0d: got %b expected %b", c, d, obs_bc(d), {m_busy, m_coll[d]});
                end
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        for (int k = 0; k < 2; k++) begin
            #2 rst_n = 1'b0;
            model_reset();
            #1;
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < 2; p++) begin
                    checks++;
                    if (obs(d, p) !== f_init(d, p)) begin
                        errors++;
                        $display("FAIL async_init k%0d d%0d p%0d: got %h expected %h", k, d, p, obs(d, p), f_init(d, p));
                    end
                end
                checks++;
                if (obs_bc(d) !== 2'b10) begin
                    errors++;
                    $display("FAIL async_busy k%0d d%0d: got %b expected 10", k, d, obs_bc(d));
                end
            end
            @(posedge clk);
            #1 rst_n = 1'b1;
            if (k == 0) begin
                for (int c = 0; c < 8; c++) begin
                    rand_inputs();
                    step();
                end
            end
        end
        test_clear();
        test_random(60);
    endtask

    initial begin
        idle();
        test_reset();
        test_clear();
        test_write_first_merge();
        test_read_first_no_change();
        test_collision();
        test_do_reg();
        test_random(400);
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
